hack_memio: RTL and testbench

- Data-memory and memory-mapped I/O stage directly downstream of the Hack CPU.
- Consumes the CPU's writeM, outM and addressM, and returns inM.
- Contains the 16K-word data RAM, an LED output register, a synchronised switch input and an 8N1 UART transmitter.
- Runs at clk50m; CPU-side accesses are qualified by the en25m enable.

---
 rtl/hack_memio_if.sv | 27 ++
 rtl/hack_memio.sv | 202 ++++++++++++++++++++
 tb/tb_hack_memio.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hack_memio_if.sv
// hack_memio_if: CPU-side data bus of the Hack memory/IO stage.
//   en25m    - CPU step enable (a write commits only when this is high)
//   writeM   - CPU write strobe
//   outM     - CPU write data
//   addressM - CPU data address
//   inM      - read data returned to the CPU
// Modports: master = CPU side, slave = memory/IO side.
interface hack_memio_if #(
  parameter int DW = 16,
  parameter int AW = 15
);
  logic          en25m;
  logic          writeM;
  logic [DW-1:0] outM;
  logic [AW-1:0] addressM;
  logic [DW-1:0] inM;

  modport master (
    output en25m, writeM, outM, addressM,
    input  inM
  );

  modport slave (
    input  en25m, writeM, outM, addressM,
    output inM
  );
endinterface

// File: rtl/hack_memio.sv
// hack_memio: data RAM plus memory-mapped LEDs, switches and an 8N1 UART
// transmitter, sitting directly downstream of the Hack CPU.
//   clk50m  - system clock
//   rst     - asynchronous reset, active-high
//   bus     - CPU data bus (slave side): en25m, writeM, outM, addressM, inM
//   sw      - asynchronous board switches (2-FF synchronised)
//   leds    - LED register contents
//   uart_tx - UART serial line, idle high
// Map: 0x0000..RAM_WORDS-1 RAM, 0x4000 LEDs, 0x4001 switches,
//      0x4002 UART data (write), 0x4003 UART status {overrun, busy}.
module hack_memio #(
  parameter int DW        = 16,
  parameter int AW        = 15,
  parameter int RAM_WORDS = 16384,
  parameter int BAUD_DIV  = 434
) (
  input  logic          clk50m,
  input  logic          rst,
  hack_memio_if.slave   bus,
  input  logic [DW-1:0] sw,
  output logic [DW-1:0] leds,
  output logic          uart_tx
);

  localparam int AWP1   = AW + 1;
  localparam int RAM_AW = $clog2(RAM_WORDS);

  localparam logic [AW:0]   RAM_LIMIT = AWP1'(RAM_WORDS);
  localparam logic [AW-1:0] ADDR_LED  = AW'(32'h4000);
  localparam logic [AW-1:0] ADDR_SW   = AW'(32'h4001);
  localparam logic [AW-1:0] ADDR_TXD  = AW'(32'h4002);
  localparam logic [AW-1:0] ADDR_STAT = AW'(32'h4003);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Decode
  logic we;
  logic addr_is_ram;
  logic [RAM_AW-1:0] ram_idx;

  assign we          = bus.en25m & bus.writeM;
  assign addr_is_ram = ({1'b0, bus.addressM} < RAM_LIMIT);
  assign ram_idx     = bus.addressM[RAM_AW-1:0];

  // Data RAM: no reset, registered read, old data on read-during-write.
  logic [DW-1:0] ram_mem [RAM_WORDS];
  logic [DW-1:0] ram_rd_q;

  always_ff @(posedge clk50m) begin
    if (we && addr_is_ram) begin
      ram_mem[ram_idx] <= bus.outM;
    end
    ram_rd_q <= ram_mem[ram_idx];
  end

  // State registers
  logic          sel_ram_q, sel_ram_d;
  logic [DW-1:0] io_rd_q, io_rd_d;
  logic [DW-1:0] leds_q, leds_d;
  logic [DW-1:0] sw_meta_q, sw_meta_d;
  logic [DW-1:0] sw_sync_q, sw_sync_d;
  logic          ovr_q, ovr_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic busy;
  logic tx_req;
  logic baud_done;

  assign busy      = (state_q != ST_IDLE);
  assign tx_req    = we && (bus.addressM == ADDR_TXD);
  assign baud_done = (baud_q == BAUD_LAST);

  // Read side: the RAM output cannot be reset, so a registered select picks
  // between it and a resettable IO read register; after reset the select
  // points at the IO register, which holds zero.
  always_comb begin
    sel_ram_d = addr_is_ram;
    io_rd_d   = '0;
    case (bus.addressM)
      ADDR_LED:  io_rd_d = leds_q;
      ADDR_SW:   io_rd_d = sw_sync_q;
      ADDR_STAT: io_rd_d = {{(DW-2){1'b0}}, ovr_q, busy};
      default:   io_rd_d = '0;
    endcase
  end

  assign bus.inM = sel_ram_q ? ram_rd_q : io_rd_q;

  // LEDs and switch synchroniser
  always_comb begin
    leds_d    = leds_q;
    if (we && (bus.addressM == ADDR_LED)) begin
      leds_d = bus.outM;
    end
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
  end

  assign leds = leds_q;

  // UART transmitter. Overrun set takes priority over a status-write clear.
  always_comb begin
    ovr_d = ovr_q;
    if (we && (bus.addressM == ADDR_STAT)) begin
      ovr_d = 1'b0;
    end
    if (tx_req && busy) begin
      ovr_d = 1'b1;
    end

    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_req) begin
          shift_d = bus.outM[7:0];
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
    endcase

    // Line level is registered from the next state so it changes on the same
    // edge as the FSM, with no combinational glitches on the pin.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign uart_tx = tx_q;

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      sel_ram_q <= 1'b0;
      io_rd_q   <= '0;
      leds_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      ovr_q     <= 1'b0;
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      sel_ram_q <= sel_ram_d;
      io_rd_q   <= io_rd_d;
      leds_q    <= leds_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      ovr_q     <= ovr_d;
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_hack_memio.sv
// tb_hack_memio: self-checking bench for hack_memio (BAUD_DIV=4).
// A behavioural model updated on every clk50m edge predicts inM, leds and
// uart_tx; a compare process checks them every cycle. Directed steps pin the
// model with literal values; a randomized phase then exercises the map.
module tb_hack_memio;
  localparam int B = 4;

  logic        clk50m = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw = 16'h0000;
  logic [15:0] leds;
  logic        uart_tx;

  hack_memio_if #(.DW(16), .AW(15)) bus();

  hack_memio #(
    .DW(16), .AW(15), .RAM_WORDS(16384), .BAUD_DIV(B)
  ) dut (
    .clk50m (clk50m),
    .rst    (rst),
    .bus    (bus),
    .sw     (sw),
    .leds   (leds),
    .uart_tx(uart_tx)
  );

  always #5 clk50m = ~clk50m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [int];
  logic [15:0] m_leds;
  logic        m_ovr;
  bit          fr_active;
  int          fr_start;
  logic [7:0]  fr_byte;
  logic [15:0] sw_d1, sw_d2;
  logic [15:0] exp_inm;
  bit          exp_known;
  logic        exp_tx;
  bit          model_ready = 0;
  int          cyc = 0;

  // A frame occupies the 10*B edges starting at the edge that accepted it.
  function automatic bit busy_after(input int e);
    return fr_active && (e >= fr_start) && ((e - fr_start) < 10 * B);
  endfunction

  always @(posedge clk50m or posedge rst) begin
    if (rst) begin
      m_leds      = 16'h0000;
      m_ovr       = 1'b0;
      fr_active   = 0;
      sw_d1       = 16'h0000;
      sw_d2       = 16'h0000;
      exp_inm     = 16'h0000;
      exp_known   = 1;
      exp_tx      = 1'b1;
      model_ready = 1;
    end else begin : model_step
      bit busy_pre;
      int a;
      int k;
      cyc++;
      busy_pre = busy_after(cyc - 1);
      a = int'(bus.addressM);
      exp_known = 1;
      if (a < 16384) begin
        exp_known = m_ram.exists(a);
        exp_inm   = exp_known ? m_ram[a] : 16'h0000;
      end else if (a == 'h4000) exp_inm = m_leds;
      else if (a == 'h4001)     exp_inm = sw_d2;
      else if (a == 'h4003)     exp_inm = {14'd0, m_ovr, busy_pre};
      else                      exp_inm = 16'h0000;

      if (bus.en25m && bus.writeM) begin
        if (a < 16384) m_ram[a] = bus.outM;
        else if (a == 'h4000) m_leds = bus.outM;
        else if (a == 'h4003) m_ovr = 1'b0;
        else if (a == 'h4002) begin
          if (busy_pre) m_ovr = 1'b1;
          else begin
            fr_active = 1;
            fr_start  = cyc;
            fr_byte   = bus.outM[7:0];
          end
        end
      end

      sw_d2 = sw_d1;
      sw_d1 = sw;

      if (busy_after(cyc)) begin
        k = (cyc - fr_start) / B;
        if (k == 0)      exp_tx = 1'b0;
        else if (k <= 8) exp_tx = fr_byte[k-1];
        else             exp_tx = 1'b1;
      end else begin
        exp_tx = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk50m) begin
    if (model_ready) begin
      check("uart_tx", {15'd0, uart_tx}, {15'd0, exp_tx});
      check("leds", leds, m_leds);
      if (exp_known) check("inM", bus.inM, exp_inm);
    end
  end

  // ---------------- stimulus ----------------
  // One CPU step: two clk50m cycles with the address held, en25m high in the
  // second. rd is inM sampled in the en25m=1 cycle.
  task automatic step(input logic wr, input logic [14:0] a, input logic [15:0] d,
                      output logic [15:0] rd);
    bus.addressM = a;
    bus.outM     = d;
    bus.writeM   = wr;
    bus.en25m    = 1'b0;
    @(negedge clk50m);
    bus.en25m = 1'b1;
    rd = bus.inM;
    @(negedge clk50m);
    bus.en25m  = 1'b0;
    bus.writeM = 1'b0;
    $display("step %s addr=0x%04h data=0x%04h inM=0x%04h", wr ? "WR" : "RD", a, d, rd);
  endtask

  // Called on the negedge right after the accepting edge; pat[j] is bit j.
  task automatic frame_check(input logic [9:0] pat, input int idle_after);
    for (int j = 0; j < 10 * B; j++) begin
      check("frame_bit", {15'd0, uart_tx}, {15'd0, pat[j/B]});
      @(negedge clk50m);
    end
    for (int j = 0; j < idle_after; j++) begin
      check("frame_idle", {15'd0, uart_tx}, 16'h0001);
      @(negedge clk50m);
    end
    $display("frame done pat=%b", pat);
  endtask

  logic [15:0] rd;
  logic [15:0] rd2;
  logic [9:0]  pat55;
  logic [14:0] addrs [13] = '{15'h0000, 15'h0001, 15'h0002, 15'h0003, 15'h0007,
                              15'h3FFF, 15'h4000, 15'h4001, 15'h4002, 15'h4003,
                              15'h4004, 15'h5000, 15'h7FFF};

  initial begin
    pat55 = 10'b1010101010;
    bus.en25m = 1'b0; bus.writeM = 1'b0; bus.outM = 16'h0; bus.addressM = 15'h0;
    repeat (3) @(negedge clk50m);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'h0001);
    check("rst_leds", leds, 16'h0000);
    check("rst_inM", bus.inM, 16'h0000);
    rst = 1'b0;

    // RAM round trip, and a write with en25m=0 must not commit
    step(1'b1, 15'h0005, 16'h1234, rd);
    step(1'b0, 15'h0005, 16'h0000, rd);
    check("ram_roundtrip", rd, 16'h1234);
    bus.addressM = 15'h0005; bus.outM = 16'hDEAD; bus.writeM = 1'b1; bus.en25m = 1'b0;
    repeat (2) @(negedge clk50m);
    bus.writeM = 1'b0;
    step(1'b0, 15'h0005, 16'h0000, rd);
    check("ram_no_en", rd, 16'h1234);

    // LEDs and switches
    step(1'b1, 15'h4000, 16'hA5A5, rd);
    check("leds_write", leds, 16'hA5A5);
    step(1'b0, 15'h4000, 16'h0000, rd);
    check("leds_read", rd, 16'hA5A5);
    sw = 16'h00FF;
    repeat (2) @(negedge clk50m);
    step(1'b0, 15'h4001, 16'h0000, rd);
    check("sw_read", rd, 16'h00FF);
    step(1'b1, 15'h4001, 16'h1234, rd);
    step(1'b0, 15'h4001, 16'h0000, rd);
    check("sw_readonly", rd, 16'h00FF);

    // Unmapped address
    step(1'b1, 15'h5000, 16'hFFFF, rd);
    step(1'b0, 15'h5000, 16'h0000, rd);
    check("unmapped_read", rd, 16'h0000);
    check("unmapped_leds", leds, 16'hA5A5);
    step(1'b0, 15'h0005, 16'h0000, rd);
    check("unmapped_ram", rd, 16'h1234);

    // Clean frame; busy visible exactly up to the last frame cycle
    step(1'b1, 15'h4002, 16'h0155, rd);
    fork
      frame_check(pat55, 4);
      begin
        repeat (38) @(negedge clk50m);
        step(1'b0, 15'h4003, 16'h0000, rd);
        step(1'b0, 15'h4003, 16'h0000, rd2);
        check("status_busy_last", rd, 16'h0001);
        check("status_after_frame", rd2, 16'h0000);
      end
    join

    // Overrun: second write dropped, frame unchanged, no second frame
    step(1'b1, 15'h4002, 16'h0155, rd);
    fork
      frame_check(pat55, 20);
      begin
        repeat (8) @(negedge clk50m);
        step(1'b1, 15'h4002, 16'h0041, rd);
        step(1'b0, 15'h4003, 16'h0000, rd);
        check("status_overrun", rd, 16'h0003);
      end
    join
    step(1'b0, 15'h4003, 16'h0000, rd);
    check("status_sticky", rd, 16'h0002);
    step(1'b1, 15'h4003, 16'h0000, rd);
    step(1'b0, 15'h4003, 16'h0000, rd);
    check("status_cleared", rd, 16'h0000);

    // Reset mid-frame during DATA bit 3
    step(1'b1, 15'h4002, 16'h0155, rd);
    repeat (17) @(negedge clk50m);
    check("data_bit3", {15'd0, uart_tx}, 16'h0000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", {15'd0, uart_tx}, 16'h0001);
    check("async_rst_leds", leds, 16'h0000);
    check("async_rst_inM", bus.inM, 16'h0000);
    repeat (2) @(negedge clk50m);
    rst = 1'b0;
    step(1'b0, 15'h4003, 16'h0000, rd);
    check("rst_status", rd, 16'h0000);
    step(1'b1, 15'h4002, 16'h0155, rd);
    frame_check(pat55, 2);
    step(1'b0, 15'h0005, 16'h0000, rd);
    check("ram_kept_over_rst", rd, 16'h1234);

    // Randomized phase, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      logic [14:0] a;
      logic        wr;
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      a  = addrs[$urandom_range(0, 12)];
      wr = 1'($urandom_range(0, 1));
      if (a == 15'h4002 && $urandom_range(0, 3) != 0) wr = 1'b0;
      step(wr, a, 16'($urandom), rd);
      repeat ($urandom_range(0, 2)) @(negedge clk50m);
    end

    repeat (2) @(negedge clk50m);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
